// File: rtl/ex_stage_unit_pkg.sv
// Shared constants and types for the execute stage: widths, ALU op codes
// and the EX/MEM pipeline register layout.
package ex_stage_unit_pkg;

   localparam int DATA_W = 32;
   localparam int PC_W   = 8;
   localparam int REG_AW = 5;
   localparam int OP_W   = 5;

   typedef enum logic [OP_W-1:0] {
      ALU_ADD   = 5'b00000,
      ALU_SUB   = 5'b00001,
      ALU_AND   = 5'b00010,
      ALU_OR    = 5'b00011,
      ALU_XOR   = 5'b00100,
      ALU_NOR   = 5'b00101,
      ALU_SLT   = 5'b00110,
      ALU_SLL   = 5'b00111,
      ALU_SRL   = 5'b01000,
      ALU_SRA   = 5'b01001,
      ALU_BEQ   = 5'b01010,
      ALU_BNE   = 5'b01011,
      ALU_PASSB = 5'b01100
   } alu_op_e;

   typedef struct packed {
      logic              mem_write;
      logic              mem_to_reg;
      logic              reg_write;
      logic              mem_read;
      logic              branch;
      logic [DATA_W-1:0] alu_result;
      logic [PC_W-1:0]   branch_target;
      logic [DATA_W-1:0] write_data;
      logic [REG_AW-1:0] write_reg;
   } ex_mem_t;

endpackage

// File: rtl/ex_stage_unit_alu.sv
// Combinational ALU for the execute stage; also produces the BEQ/BNE condition.
// The barrel shifter is only built when EX_STAGE_SHIFT_EN is defined.
module ex_alu
   import ex_stage_unit_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  alu_op_e           op,
   output logic [DATA_W-1:0] result,
   output logic              cond
);

   logic [DATA_W-1:0] diff;

   assign diff = a - b;

   always_comb begin
      result = '0;
      cond   = 1'b0;
      case (op)
         ALU_ADD:   result = a + b;
         ALU_SUB:   result = diff;
         ALU_AND:   result = a & b;
         ALU_OR:    result = a | b;
         ALU_XOR:   result = a ^ b;
         ALU_NOR:   result = ~(a | b);
         ALU_SLT:   result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef EX_STAGE_SHIFT_EN
         ALU_SLL:   result = a << b[4:0];
         ALU_SRL:   result = a >> b[4:0];
         ALU_SRA:   result = $unsigned($signed(a) >>> b[4:0]);
`endif
         ALU_BEQ: begin
            result = diff;
            cond   = (a == b);
         end
         ALU_BNE: begin
            result = diff;
            cond   = (a != b);
         end
         ALU_PASSB: result = b;
         default:   result = '0;
      endcase
   end

endmodule

// File: rtl/ex_stage_unit.sv
// Execute stage: operand select, ALU, branch target/decision, EX/MEM register.
// Optional macro EX_STAGE_SHIFT_EN enables SLL/SRL/SRA in the ALU.
module ex_stage_unit
   import ex_stage_unit_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              ID_EX_RegDst,
   input  logic              ID_EX_ALUSrc,
   input  logic              ID_EX_MemtoReg,
   input  logic              ID_EX_RegWrite,
   input  logic              ID_EX_MemRead,
   input  logic              ID_EX_MemWrite,
   input  logic              ID_EX_Branch,
   input  logic [OP_W-1:0]   ID_EX_ALUOp,
   input  logic [PC_W-1:0]   ID_EX_PC,
   input  logic [REG_AW-1:0] ID_EX_Rb,
   input  logic [REG_AW-1:0] ID_EX_Rd,
   input  logic [DATA_W-1:0] ID_EX_ReadData1,
   input  logic [DATA_W-1:0] ID_EX_ReadData2,
   input  logic [DATA_W-1:0] ID_EX_SignExtImm,
   output logic              EX_MEM_MemWriteOut,
   output logic              EX_MEM_MemtoRegOut,
   output logic              EX_MEM_RegWrite,
   output logic              EX_MEM_MemReadOut,
   output logic              EX_MEM_Branch,
   output logic [DATA_W-1:0] EX_MEM_ALUResult,
   output logic [PC_W-1:0]   EX_MEM_BranchTarget,
   output logic [DATA_W-1:0] EX_MEM_WriteData,
   output logic [REG_AW-1:0] EX_MEM_WriteReg
);

   logic [DATA_W-1:0] alu_b;
   logic [DATA_W-1:0] alu_result;
   logic              alu_cond;
   ex_mem_t           ex_mem_d;
   ex_mem_t           ex_mem_q;

   assign alu_b = ID_EX_ALUSrc ? ID_EX_SignExtImm : ID_EX_ReadData2;

   ex_alu u_alu (
      .a      (ID_EX_ReadData1),
      .b      (alu_b),
      .op     (alu_op_e'(ID_EX_ALUOp)),
      .result (alu_result),
      .cond   (alu_cond)
   );

   always_comb begin
      ex_mem_d               = '0;
      ex_mem_d.mem_write     = ID_EX_MemWrite;
      ex_mem_d.mem_to_reg    = ID_EX_MemtoReg;
      ex_mem_d.reg_write     = ID_EX_RegWrite;
      ex_mem_d.mem_read      = ID_EX_MemRead;
      ex_mem_d.branch        = ID_EX_Branch & alu_cond;
      ex_mem_d.alu_result    = alu_result;
      // target is computed every cycle, wrapping modulo 256
      ex_mem_d.branch_target = ID_EX_PC + ID_EX_SignExtImm[PC_W-1:0];
      ex_mem_d.write_data    = ID_EX_ReadData2;
      ex_mem_d.write_reg     = ID_EX_RegDst ? ID_EX_Rd : ID_EX_Rb;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ex_mem_q <= '0;
      else     ex_mem_q <= ex_mem_d;
   end

   assign EX_MEM_MemWriteOut  = ex_mem_q.mem_write;
   assign EX_MEM_MemtoRegOut  = ex_mem_q.mem_to_reg;
   assign EX_MEM_RegWrite     = ex_mem_q.reg_write;
   assign EX_MEM_MemReadOut   = ex_mem_q.mem_read;
   assign EX_MEM_Branch       = ex_mem_q.branch;
   assign EX_MEM_ALUResult    = ex_mem_q.alu_result;
   assign EX_MEM_BranchTarget = ex_mem_q.branch_target;
   assign EX_MEM_WriteData    = ex_mem_q.write_data;
   assign EX_MEM_WriteReg     = ex_mem_q.write_reg;

endmodule

// File: tb/tb_ex_stage_unit.sv
// Directed self-checking bench for ex_stage_unit (expected values adapt to EX_STAGE_SHIFT_EN).
module tb_ex_stage_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch;
   logic [4:0]  alu_op;
   logic [7:0]  pc;
   logic [4:0]  rb, rd;
   logic [31:0] rd1, rd2, imm;

   logic        o_mem_write, o_mem_to_reg, o_reg_write, o_mem_read, o_branch;
   logic [31:0] o_alu_result, o_write_data;
   logic [7:0]  o_branch_target;
   logic [4:0]  o_write_reg;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ex_stage_unit dut (
      .clk                 (clk),
      .rst                 (rst),
      .ID_EX_RegDst        (reg_dst),
      .ID_EX_ALUSrc        (alu_src),
      .ID_EX_MemtoReg      (mem_to_reg),
      .ID_EX_RegWrite      (reg_write),
      .ID_EX_MemRead       (mem_read),
      .ID_EX_MemWrite      (mem_write),
      .ID_EX_Branch        (branch),
      .ID_EX_ALUOp         (alu_op),
      .ID_EX_PC            (pc),
      .ID_EX_Rb            (rb),
      .ID_EX_Rd            (rd),
      .ID_EX_ReadData1     (rd1),
      .ID_EX_ReadData2     (rd2),
      .ID_EX_SignExtImm    (imm),
      .EX_MEM_MemWriteOut  (o_mem_write),
      .EX_MEM_MemtoRegOut  (o_mem_to_reg),
      .EX_MEM_RegWrite     (o_reg_write),
      .EX_MEM_MemReadOut   (o_mem_read),
      .EX_MEM_Branch       (o_branch),
      .EX_MEM_ALUResult    (o_alu_result),
      .EX_MEM_BranchTarget (o_branch_target),
      .EX_MEM_WriteData    (o_write_data),
      .EX_MEM_WriteReg     (o_write_reg)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".ctrl"}, {27'b0, o_mem_write, o_mem_to_reg, o_reg_write, o_mem_read, o_branch}, 32'h0);
      check({tag, ".alu"},  o_alu_result, 32'h0);
      check({tag, ".tgt"},  {24'b0, o_branch_target}, 32'h0);
      check({tag, ".wdat"}, o_write_data, 32'h0);
      check({tag, ".wreg"}, {27'b0, o_write_reg}, 32'h0);
   endtask

   task automatic clear_inputs();
      reg_dst = 0; alu_src = 0; mem_to_reg = 0; reg_write = 0;
      mem_read = 0; mem_write = 0; branch = 0; alu_op = 5'b00000;
      pc = 8'h00; rb = 5'd0; rd = 5'd0; rd1 = 0; rd2 = 0; imm = 0;
   endtask

   // one pipeline edge, then sample 1 time unit after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic alu_vec(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
      clear_inputs();
      alu_op = op; rd1 = a; rd2 = b;
      tick();
      check(tag, o_alu_result, exp);
   endtask

   initial begin
      // reset with arbitrary non-zero inputs
      rst = 1'b1;
      reg_dst = 1; alu_src = 1; mem_to_reg = 1; reg_write = 1; mem_read = 1;
      mem_write = 1; branch = 1; alu_op = 5'b01010; pc = 8'h33; rb = 5'd7; rd = 5'd9;
      rd1 = 32'h1234_5678; rd2 = 32'h1234_5678; imm = 32'h55;
      tick();
      tick();
      check_all_zero("reset");

      // LW address; first edge after rst falls captures inputs
      rst = 1'b0;
      clear_inputs();
      alu_op = 5'b00000; alu_src = 1; mem_read = 1; reg_write = 1; mem_to_reg = 1;
      reg_dst = 0; rd1 = 32'h10; imm = 32'd4; rb = 5'd3; rd = 5'd12;
      tick();
      check("lw.alu", o_alu_result, 32'h14);
      check("lw.ctrl", {27'b0, o_mem_write, o_mem_to_reg, o_reg_write, o_mem_read, o_branch}, 32'b01110);
      check("lw.wreg", {27'b0, o_write_reg}, 32'd3);

      // SW: negative offset, store data is ReadData2 despite ALUSrc=1
      clear_inputs();
      alu_op = 5'b00000; alu_src = 1; mem_write = 1;
      rd1 = 32'h100; rd2 = 32'hDEAD_BEEF; imm = 32'hFFFF_FFFC;
      tick();
      check("sw.alu", o_alu_result, 32'hFC);
      check("sw.wdat", o_write_data, 32'hDEAD_BEEF);
      check("sw.ctrl", {27'b0, o_mem_write, o_mem_to_reg, o_reg_write, o_mem_read, o_branch}, 32'b10000);

      // BEQ taken / not taken; target registered either way
      clear_inputs();
      branch = 1; alu_op = 5'b01010; rd1 = 7; rd2 = 7; pc = 8'd8; imm = 32'd8;
      tick();
      check("beq_t.br", {31'b0, o_branch}, 32'd1);
      check("beq_t.tgt", {24'b0, o_branch_target}, 32'd16);
      check("beq_t.alu", o_alu_result, 32'd0);
      rd2 = 6;
      tick();
      check("beq_n.br", {31'b0, o_branch}, 32'd0);
      check("beq_n.tgt", {24'b0, o_branch_target}, 32'd16);
      check("beq_n.alu", o_alu_result, 32'd1);

      // BNE taken, then gated off by ID_EX_Branch=0
      alu_op = 5'b01011;
      tick();
      check("bne_t.br", {31'b0, o_branch}, 32'd1);
      branch = 0;
      tick();
      check("bne_gate.br", {31'b0, o_branch}, 32'd0);

      // target wrap, and non-branch op never takes a branch
      clear_inputs();
      branch = 1; alu_op = 5'b00000; rd1 = 3; rd2 = 3; pc = 8'hFE; imm = 32'd3;
      tick();
      check("wrap.tgt", {24'b0, o_branch_target}, 32'h01);
      check("wrap.br", {31'b0, o_branch}, 32'd0);

      alu_vec("slt_neg",  5'b00110, 32'hFFFF_FFFF, 32'd1, 32'd1);
      alu_vec("slt_pos",  5'b00110, 32'd1, 32'hFFFF_FFFF, 32'd0);
      alu_vec("add_wrap", 5'b00000, 32'hFFFF_FFFF, 32'd1, 32'd0);
      alu_vec("and",      5'b00010, 32'hF0F0_FF00, 32'h0FF0_F0F0, 32'h00F0_F000);
      alu_vec("or",       5'b00011, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F);
      alu_vec("xor",      5'b00100, 32'hFFFF_0000, 32'hF0F0_F0F0, 32'h0F0F_F0F0);
      alu_vec("nor",      5'b00101, 32'hF0F0_0000, 32'h0000_0F0F, 32'h0F0F_F0F0);
      alu_vec("passb",    5'b01100, 32'h1111_1111, 32'hABCD_0000, 32'hABCD_0000);
      alu_vec("unused",   5'b11111, 32'h1111_1111, 32'h2222_2222, 32'h0);
`ifdef EX_STAGE_SHIFT_EN
      alu_vec("sra", 5'b01001, 32'h8000_0000, 32'd4,  32'hF800_0000);
      alu_vec("srl", 5'b01000, 32'h8000_0000, 32'd4,  32'h0800_0000);
      alu_vec("sll", 5'b00111, 32'h0000_0001, 32'd31, 32'h8000_0000);
      alu_vec("sll_b40", 5'b00111, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002);
`else
      alu_vec("sra", 5'b01001, 32'h8000_0000, 32'd4,  32'h0);
      alu_vec("srl", 5'b01000, 32'h8000_0000, 32'd4,  32'h0);
      alu_vec("sll", 5'b00111, 32'h0000_0001, 32'd31, 32'h0);
`endif

      // R-type SUB, destination Rd
      clear_inputs();
      reg_dst = 1; alu_src = 0; alu_op = 5'b00001; rd1 = 5; rd2 = 7; imm = 32'd100;
      rd = 5'd9; rb = 5'd4; reg_write = 1;
      tick();
      check("sub.alu", o_alu_result, 32'hFFFF_FFFE);
      check("sub.wreg", {27'b0, o_write_reg}, 32'd9);
      check("sub.rw", {31'b0, o_reg_write}, 32'd1);

      // mid-cycle reset clears immediately, stays clear across an edge
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("midrst");
      tick();
      check_all_zero("midrst_hold");
      rst = 1'b0;
      tick();
      check("post_rst.alu", o_alu_result, 32'hFFFF_FFFE);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
